// File: rtl/stepper_sequencer.sv
// Stepper motor phase sequencer.
// Walks a 3-bit phase index through an 8-entry coil table, moving one step
// per upstream timer tick in half-step (+/-1) or full-step (+/-2) mode.
// Build option: define HOLD_TORQUE_EN to keep the coils energized with the
// last pattern while idle; otherwise the coils are released on return to IDLE.
module stepper_sequencer #(
  parameter int COUNT_BITS = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Go,
  input  logic                  Abort,
  input  logic                  Direction,
  input  logic                  HalfStep,
  input  logic [COUNT_BITS-1:0] StepCount,
  input  logic                  Timeout,
  output logic                  Start,
  output logic [3:0]            Coils,
  output logic                  Busy,
  output logic                  Done,
  output logic [COUNT_BITS-1:0] Remaining
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [COUNT_BITS-1:0] ONE  = {{(COUNT_BITS-1){1'b0}}, 1'b1};
  localparam logic [COUNT_BITS-1:0] ZERO = '0;

  state_t                state_q;
  logic [2:0]            index_q;
  logic [3:0]            coils_q;
  logic [COUNT_BITS-1:0] remaining_q;
  logic                  dir_q;
  logic                  half_q;

  logic [2:0]            step_size;
  logic [2:0]            index_d;

  // Coil pattern for each phase; even phases drive one coil, odd phases two.
  function automatic logic [3:0] phase_pattern(input logic [2:0] idx);
    logic [3:0] pat;
    case (idx)
      3'd0:    pat = 4'b1000;
      3'd1:    pat = 4'b1100;
      3'd2:    pat = 4'b0100;
      3'd3:    pat = 4'b0110;
      3'd4:    pat = 4'b0010;
      3'd5:    pat = 4'b0011;
      3'd6:    pat = 4'b0001;
      default: pat = 4'b1001;
    endcase
    return pat;
  endfunction

  // Next phase index for one step; 3-bit arithmetic wraps modulo 8 and a
  // full step of 2 keeps the index parity.
  always_comb begin
    step_size = half_q ? 3'd1 : 3'd2;
    index_d   = dir_q ? (index_q + step_size) : (index_q - step_size);
  end

  // Move-control FSM with the phase index, coil drive and step counter.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      index_q     <= 3'd0;
      coils_q     <= 4'b0000;
      remaining_q <= ZERO;
      dir_q       <= 1'b0;
      half_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Go) begin
            if (StepCount != ZERO) begin
              // Direction and step size are frozen for the whole move.
              dir_q       <= Direction;
              half_q      <= HalfStep;
              remaining_q <= StepCount;
              coils_q     <= phase_pattern(index_q);
              state_q     <= RUN;
            end else begin
              // Empty move: report completion without touching the motor.
              state_q <= FINISH;
            end
          end
        end
        RUN: begin
          if (Abort) begin
            // Early stop wins over a coincident tick; everything holds.
            state_q <= FINISH;
          end else if (Timeout) begin
            index_q     <= index_d;
            coils_q     <= phase_pattern(index_d);
            remaining_q <= remaining_q - ONE;
            if (remaining_q == ONE) begin
              state_q <= FINISH;
            end
          end
        end
        FINISH: begin
          state_q <= IDLE;
`ifdef HOLD_TORQUE_EN
          // Keep the last pattern so the rotor stays locked in place.
`else
          // Release the coils; the index is kept so the next move resumes.
          coils_q <= 4'b0000;
`endif
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Start     = (state_q == RUN);
  assign Busy      = (state_q == RUN);
  assign Done      = (state_q == FINISH);
  assign Coils     = coils_q;
  assign Remaining = remaining_q;

endmodule

// File: tb/tb_stepper_sequencer.sv
// Scoreboard bench for stepper_sequencer: the stimulus process drives inputs
// and pushes the reference model's expected outputs for each clock edge; a
// separate monitor pops and compares on the falling edge.
module tb_stepper_sequencer;

  localparam int CB = 8;

  logic          Clock = 1'b0;
  logic          Reset, Go, Abort, Direction, HalfStep, Timeout;
  logic [CB-1:0] StepCount;
  logic          Start, Busy, Done;
  logic [3:0]    Coils;
  logic [CB-1:0] Remaining;

  stepper_sequencer #(.COUNT_BITS(CB)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Go        (Go),
    .Abort     (Abort),
    .Direction (Direction),
    .HalfStep  (HalfStep),
    .StepCount (StepCount),
    .Timeout   (Timeout),
    .Start     (Start),
    .Coils     (Coils),
    .Busy      (Busy),
    .Done      (Done),
    .Remaining (Remaining)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [3:0]    coils;
    logic          busy;
    logic          start;
    logic          done;
    logic [CB-1:0] rem;
  } exp_t;

  exp_t exp_q[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;
  int   n_moves      = 0;

  // Reference model: motor position as an unbounded integer, phase = pos mod 8.
  logic [3:0] tab [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                          4'b0010, 4'b0011, 4'b0001, 4'b1001};
  int         m_pos;
  bit         m_moving, m_done, m_fwd, m_half;
  int         m_left;
  logic [3:0] m_coils;

  function automatic int phase_of(input int pos);
    return ((pos % 8) + 8) % 8;
  endfunction

  // Advance the model by one clock edge with the current inputs, then
  // queue what the outputs should show after that edge.
  task automatic model_edge();
    exp_t e;
    if (Reset) begin
      m_moving = 0; m_done = 0; m_pos = 0; m_coils = 4'b0000; m_left = 0;
    end else if (m_done) begin
      m_done = 0;
`ifndef HOLD_TORQUE_EN
      m_coils = 4'b0000;
`endif
    end else if (m_moving) begin
      if (Abort) begin
        m_moving = 0; m_done = 1;
      end else if (Timeout) begin
        m_pos   = m_pos + (m_fwd ? 1 : -1) * (m_half ? 1 : 2);
        m_coils = tab[phase_of(m_pos)];
        m_left  = m_left - 1;
        if (m_left == 0) begin
          m_moving = 0; m_done = 1;
        end
      end
    end else if (Go) begin
      if (StepCount != 0) begin
        m_moving = 1; m_fwd = Direction; m_half = HalfStep;
        m_left = int'(StepCount);
        m_coils = tab[phase_of(m_pos)];
      end else begin
        m_done = 1;
      end
    end
    e.coils = m_coils;
    e.busy  = m_moving;
    e.start = m_moving;
    e.done  = m_done;
    e.rem   = CB'(m_left);
    exp_q.push_back(e);
  endtask

  task automatic cycle();
    model_edge();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_inputs();
    Reset = 0; Go = 0; Abort = 0; Timeout = 0;
  endtask

  task automatic tick_after(input int gap);
    idle_inputs();
    repeat (gap) cycle();
    Timeout = 1;
    cycle();
    Timeout = 0;
  endtask

  task automatic check(input string name, input int act, input int req);
    n_compared++;
    if (act != req) begin
      n_mismatched++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  // Monitor: every falling edge the DUT presents a fresh set of outputs.
  always @(negedge Clock) begin
    exp_t e;
    if (exp_q.size() == 0) begin
      check("queue_underflow", 0, 1);
    end else begin
      e = exp_q.pop_front();
      check("coils",     int'(Coils),     int'(e.coils));
      check("busy",      int'(Busy),      int'(e.busy));
      check("start",     int'(Start),     int'(e.start));
      check("done",      int'(Done),      int'(e.done));
      check("remaining", int'(Remaining), int'(e.rem));
      if (e.done) begin
        n_moves++;
        $display("move %0d complete: coils=%b remaining=%0d", n_moves, Coils, Remaining);
      end
    end
  end

  initial begin
    Direction = 0; HalfStep = 0; StepCount = '0;
    idle_inputs();

    // Reset held two cycles while Go is asserted.
    Reset = 1; Go = 1; StepCount = 8'd5;
    cycle(); cycle();
    idle_inputs();
    cycle();

    // Half-step forward, 3 steps, ticks 5 cycles apart.
    HalfStep = 1; Direction = 1; StepCount = 8'd3; Go = 1;
    cycle();
    Go = 0; Direction = 0; HalfStep = 0;   // must be ignored mid-move
    tick_after(4); tick_after(4); tick_after(4);
    cycle(); cycle();

    // Reset to index 0, then full-step reverse, 2 steps.
    Reset = 1; cycle(); idle_inputs(); cycle();
    HalfStep = 0; Direction = 0; StepCount = 8'd2; Go = 1;
    cycle();
    tick_after(1); tick_after(2);
    cycle(); cycle();

    // Zero-length move, with Go held through FINISH.
    StepCount = 8'd0; Go = 1;
    cycle(); cycle(); cycle();
    idle_inputs(); cycle();

    // Abort coinciding with a tick at Remaining=4.
    HalfStep = 1; Direction = 1; StepCount = 8'd6; Go = 1;
    cycle();
    tick_after(0); tick_after(0);
    Abort = 1; Timeout = 1; cycle();
    idle_inputs(); cycle(); cycle();

    // Reset after two steps of a move: no Done, index back to 0.
    HalfStep = 0; Direction = 1; StepCount = 8'd5; Go = 1;
    cycle();
    tick_after(0); tick_after(0);
    Reset = 1; cycle();
    idle_inputs(); cycle(); cycle();
    StepCount = 8'd1; Go = 1; cycle();
    tick_after(1);
    cycle(); cycle();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      Reset     = ($urandom_range(0, 199) == 0);
      Go        = ($urandom_range(0, 3) == 0);
      Abort     = ($urandom_range(0, 24) == 0);
      Timeout   = ($urandom_range(0, 2) == 0);
      Direction = 1'($urandom_range(0, 1));
      HalfStep  = 1'($urandom_range(0, 1));
      StepCount = CB'($urandom_range(0, 9));
      cycle();
    end
    idle_inputs();
    cycle();

    @(negedge Clock);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
